// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave controller slice.
//   state_t        : controller FSM encoding
//   BCD_MAX_DIGIT  : largest legal keypad digit
//   SEC_TENS_WRAP  : value loaded into the tens-of-seconds digit on a minute borrow
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] SEC_TENS_WRAP = 4'd5;

endpackage

// File: rtl/microwave_controller_bcd_timer.sv
// Three-digit BCD countdown (M:ST) for the microwave controller.
// Ports:
//   clk, rst          : clock, async active-high reset
//   clr               : synchronous clear of all digits
//   load, d           : shift d in as the new seconds-ones digit
//   dec               : count down one second (ignored at 0:00)
//   mins/sec_tens/sec_ones : current time
//   zero              : time is 0:00
//   last              : time is 0:01, so the next decrement reaches 0:00
module bcd_timer
    import microwave_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] d,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       last
);

    assign zero = (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign last = (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mins     <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
        end else if (clr) begin
            mins     <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
        end else if (load) begin
            mins     <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= d;
        end else if (dec && !zero) begin
            // Tens digits above 5 are counted down as entered; only the
            // minute borrow reloads the wrap value.
            if (sec_ones != 4'd0) begin
                sec_ones <= sec_ones - 4'd1;
            end else begin
                sec_ones <= BCD_MAX_DIGIT;
                if (sec_tens != 4'd0) begin
                    sec_tens <= sec_tens - 4'd1;
                end else begin
                    sec_tens <= SEC_TENS_WRAP;
                    mins     <= mins - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/microwave_controller.sv
// Microwave oven controller: keypad time entry, cook countdown, pause on
// door open / stop, and a timed done indication.
// Ports:
//   clk, clear        : clock, async active-high reset
//   D, loadn          : keypad BCD digit and active-low digit strobe
//   pgt_1hz           : 1 Hz tick from the encoder
//   startn, stopn     : active-low push-buttons
//   door_closed       : 1 = door closed
//   enablen           : 0 = keypad entry, 1 = timing mode
//   mag_on            : magnetron drive
//   mins/sec_tens/sec_ones : BCD time display
//   done              : cook-complete indication
module microwave_controller
    import microwave_pkg::*;
#(
    parameter int DONE_SECONDS = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1hz,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic       enablen,
    output logic       mag_on,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       done
);

    localparam int CW = (DONE_SECONDS > 1) ? $clog2(DONE_SECONDS) : 1;

    state_t        state;
    logic [CW-1:0] done_cnt;

    // Previous-cycle copies of the strobes; reset to their idle levels so
    // that leaving reset never looks like an edge.
    logic loadn_q, pgt_q, startn_q, stopn_q;
    logic load_fall, tick, start_fall, stop_fall;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            loadn_q  <= 1'b1;
            pgt_q    <= 1'b0;
            startn_q <= 1'b1;
            stopn_q  <= 1'b1;
        end else begin
            loadn_q  <= loadn;
            pgt_q    <= pgt_1hz;
            startn_q <= startn;
            stopn_q  <= stopn;
        end
    end

    assign load_fall  = loadn_q  & ~loadn;
    assign tick       = ~pgt_q   &  pgt_1hz;
    assign start_fall = startn_q & ~startn;
    assign stop_fall  = stopn_q  & ~stopn;

    // Timer controls are decoded from the current state and edges; the FSM
    // below makes the matching state decision on the same edge.
    logic t_clr, t_load, t_dec, t_zero, t_last, go;

    assign go = start_fall & door_closed & ~t_zero;

    always_comb begin
        t_clr  = 1'b0;
        t_load = 1'b0;
        t_dec  = 1'b0;
        case (state)
            IDLE: begin
                t_clr  = stop_fall;
                t_load = ~stop_fall & ~go & load_fall & (D <= BCD_MAX_DIGIT);
            end
            COOK:    t_dec = ~stop_fall & door_closed & tick;
            PAUSE:   t_clr = stop_fall;
            DONE:    t_clr = stop_fall;
            default: ;
        endcase
    end

    bcd_timer u_timer (
        .clk      (clk),
        .rst      (clear),
        .clr      (t_clr),
        .load     (t_load),
        .dec      (t_dec),
        .d        (D),
        .mins     (mins),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .zero     (t_zero),
        .last     (t_last)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            done_cnt <= '0;
            done     <= 1'b0;
            mag_on   <= 1'b0;
            enablen  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    mag_on  <= 1'b0;
                    enablen <= 1'b0;
                    if (!stop_fall && go) begin
                        state   <= COOK;
                        mag_on  <= 1'b1;
                        enablen <= 1'b1;
                    end
                end
                COOK: begin
                    if (stop_fall || !door_closed) begin
                        state  <= PAUSE;
                        mag_on <= 1'b0;
                    end else if (tick && t_last) begin
                        state    <= DONE;
                        mag_on   <= 1'b0;
                        done     <= 1'b1;
                        done_cnt <= '0;
                    end
                end
                PAUSE: begin
                    if (stop_fall) begin
                        state   <= IDLE;
                        enablen <= 1'b0;
                    end else if (start_fall && door_closed) begin
                        state  <= COOK;
                        mag_on <= 1'b1;
                    end
                end
                DONE: begin
                    if (stop_fall || (tick && done_cnt == CW'(DONE_SECONDS - 1))) begin
                        state   <= IDLE;
                        done    <= 1'b0;
                        enablen <= 1'b0;
                    end else if (tick) begin
                        done_cnt <= done_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_microwave_controller.sv
// Directed bench for microwave_controller: key entry, full cook, borrow,
// door open, start blocking, stop priority and async clear.
module tb_microwave_controller;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] D;
    logic       loadn, pgt_1hz, startn, stopn, door_closed;
    logic       enablen, mag_on, done;
    logic [3:0] mins, sec_tens, sec_ones;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    microwave_controller #(.DONE_SECONDS(3)) dut (
        .clk         (clk),
        .clear       (clear),
        .D           (D),
        .loadn       (loadn),
        .pgt_1hz     (pgt_1hz),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .enablen     (enablen),
        .mag_on      (mag_on),
        .mins        (mins),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .done        (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] tm();
        return {mins, sec_tens, sec_ones};
    endfunction

    // Checks are made after the first step, i.e. just after the edge that
    // saw the falling/rising strobe.
    task automatic key(input logic [3:0] d);
        D = d; loadn = 1'b0; step(); loadn = 1'b1; step();
    endtask

    task automatic press_start();
        startn = 1'b0; step(); startn = 1'b1;
    endtask

    task automatic press_stop();
        stopn = 1'b0; step(); stopn = 1'b1;
    endtask

    task automatic tick();
        pgt_1hz = 1'b1; step(); pgt_1hz = 1'b0;
    endtask

    initial begin
        clear = 1'b1; D = 4'd0; loadn = 1'b1; pgt_1hz = 1'b0;
        startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
        step(); step();
        clear = 1'b0;
        step();
        chk("rst_time", tm(), 12'h000);
        chk("rst_outs", {9'd0, enablen, mag_on, done}, 12'h000);

        // key entry
        key(4'd1); chk("key1", tm(), 12'h001);
        key(4'd3); key(4'd0);
        chk("key130", tm(), 12'h130);
        key(4'hC); chk("key_bad", tm(), 12'h130);
        chk("idle_en", {11'd0, enablen}, 12'h000);
        press_stop(); step();
        chk("idle_stop", tm(), 12'h000);

        // start blocked: zero time, then door open
        press_start(); step();
        chk("blk_zero", {10'd0, enablen, mag_on}, 12'h000);
        key(4'd3);
        door_closed = 1'b0;
        press_start(); step();
        chk("blk_door", {10'd0, enablen, mag_on}, 12'h000);
        door_closed = 1'b1;

        // full cook from 0:03
        press_start();
        chk("cook_on", {10'd0, enablen, mag_on}, 12'h003);
        step();
        tick(); chk("cook_t1", tm(), 12'h002); chk("cook_mag1", {11'd0, mag_on}, 12'h001);
        step();
        tick(); chk("cook_t2", tm(), 12'h001); chk("cook_mag2", {11'd0, mag_on}, 12'h001);
        step();
        tick(); chk("cook_t3", tm(), 12'h000);
        chk("done_entry", {10'd0, mag_on, done}, 12'h001);
        step();
        key(4'd7); chk("done_nokey", tm(), 12'h000);
        tick(); step(); chk("done_d1", {10'd0, enablen, done}, 12'h003);
        tick(); step(); chk("done_d2", {10'd0, enablen, done}, 12'h003);
        tick(); step(); chk("done_exit", {10'd0, enablen, done}, 12'h000);

        // borrow across a minute
        key(4'd1); key(4'd0); key(4'd0);
        press_start(); step();
        tick(); step(); chk("borrow_min", tm(), 12'h059);
        press_stop(); step(); press_stop(); step();
        chk("stop_clear", tm(), 12'h000);
        key(4'd1); key(4'd0);
        press_start(); step();
        tick(); step(); chk("borrow_ten", tm(), 12'h009);
        press_stop(); step(); press_stop(); step();

        // sec_tens above 5 counts down unchanged
        key(4'd9); key(4'd0);
        press_start(); step();
        tick(); step(); chk("tens9", tm(), 12'h089);
        press_stop(); step(); press_stop(); step();

        // door open coinciding with a tick
        key(4'd4); key(4'd5);
        press_start(); step();
        door_closed = 1'b0; pgt_1hz = 1'b1; step(); pgt_1hz = 1'b0;
        chk("door_time", tm(), 12'h045);
        chk("door_outs", {10'd0, enablen, mag_on}, 12'h002);
        step();
        door_closed = 1'b1;
        press_start(); chk("resume_mag", {11'd0, mag_on}, 12'h001);
        step();
        tick(); step(); chk("resume_time", tm(), 12'h044);

        // stop wins over simultaneous start in PAUSE
        press_stop(); step();
        startn = 1'b0; stopn = 1'b0; step(); startn = 1'b1; stopn = 1'b1;
        chk("prio_time", tm(), 12'h000);
        chk("prio_outs", {10'd0, enablen, mag_on}, 12'h000);
        step();

        // asynchronous clear mid-cook
        key(4'd5);
        press_start(); step();
        chk("pre_clr_mag", {11'd0, mag_on}, 12'h001);
        #2 clear = 1'b1;
        #1;
        chk("aclr_outs", {10'd0, enablen, mag_on}, 12'h000);
        chk("aclr_time", tm(), 12'h000);
        #1 clear = 1'b0;
        step(); step();
        chk("post_clr", {9'd0, enablen, mag_on, done}, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/microwave_controller.md
MICROWAVE_CONTROLLER -- requirements
Module: microwave_controller

Interface
REQ-001 SHALL have parameter DONE_SECONDS, default 3, number of 1 Hz ticks the done indication stays asserted.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port clear, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port D, input, 4, BCD digit from the keypad encoder.
REQ-005 SHALL have port loadn, input, 1, encoder digit-valid strobe, active-low.
REQ-006 SHALL have port pgt_1hz, input, 1, encoder 1 Hz tick, counted on rising edge.
REQ-007 SHALL have ports startn and stopn, input, 1 each, push-buttons, active-low.
REQ-008 SHALL have port door_closed, input, 1, 1 = door closed.
REQ-009 SHALL have port enablen, output, 1, encoder enable: 0 = keypad entry, 1 = timing mode.
REQ-010 SHALL have port mag_on, output, 1, magnetron drive.
REQ-011 SHALL have ports mins, sec_tens and sec_ones, output, 4 each, BCD time for display.
REQ-012 SHALL have port done, output, 1, cook-complete indication.

Function
REQ-013 SHALL register loadn, pgt_1hz, startn and stopn once, and act only on detected edges: loadn fall, pgt_1hz rise, startn fall, stopn fall.
REQ-014 SHALL implement FSM states IDLE, COOK, PAUSE and DONE.
REQ-015 IDLE SHALL drive enablen=0 and mag_on=0; on a loadn fall with D<=9, shift digits: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=D.
REQ-016 IDLE SHALL ignore a loadn fall with D>9; keys in any other state SHALL be ignored.
REQ-017 IDLE SHALL go to COOK on a startn fall only if door_closed=1 and the time is nonzero; otherwise it SHALL stay in IDLE.
REQ-018 IDLE SHALL clear all digits to 0 on a stopn fall.
REQ-019 COOK SHALL drive enablen=1 and mag_on=1.
REQ-020 COOK SHALL decrement the time once per pgt_1hz rise using these rules:
  - sec_ones>0: sec_ones-1;
  - else sec_ones=9 and, if sec_tens>0, sec_tens-1;
  - else sec_tens=5 and mins-1.
REQ-021 Entered sec_tens values 6-9 SHALL be counted down as-is, with no normalisation.
REQ-022 The decrement that yields 0:00 SHALL enter DONE on the same edge; mag_on SHALL be 0 from the next cycle.
REQ-023 COOK SHALL go to PAUSE when door_closed=0 or on a stopn fall; a simultaneous tick SHALL NOT decrement.
REQ-024 PAUSE SHALL drive enablen=1 and mag_on=0 and hold the time.
REQ-025 PAUSE SHALL go to COOK on a startn fall with door_closed=1, and SHALL go to IDLE with digits cleared on a stopn fall.
REQ-026 DONE SHALL drive done=1, enablen=1 and mag_on=0.
REQ-027 DONE SHALL count DONE_SECONDS pgt_1hz rises, then go to IDLE; a stopn fall SHALL go to IDLE at once.
REQ-028 In every state, a stopn fall coinciding with a startn fall SHALL win (stop has priority).
REQ-029 mag_on SHALL never be 1 while door_closed=0 for more than the one cycle needed to register the input.

Reset
REQ-030 clear=1 SHALL asynchronously force state IDLE, all digits to 0, and the DONE counter, done, mag_on and enablen to 0.
REQ-031 Edge-detect registers SHALL reset to the inactive level (loadn, startn, stopn = 1; pgt_1hz = 0), so no false edge occurs after reset.
REQ-032 clear asserted mid-cook SHALL drop mag_on immediately, without waiting for a clock edge.

Structure
REQ-033 The state encoding and the BCD_MAX_DIGIT=9 / SEC_TENS_WRAP=5 constants SHALL live in the shared microwave package.
REQ-034 The BCD countdown SHALL be a sub-module bcd_timer with load/shift, tick-decrement and zero-flag outputs; the FSM stays in microwave_controller.

Verification
REQ-035 The bench SHALL cover key entry: from reset, key sequence 1,3,0 -> display 1:30; key with D=4'hC -> display unchanged.
REQ-036 The bench SHALL cover a full cook: 0:03 entered, door closed, start, 3 ticks -> time 0:02, 0:01, 0:00 with mag_on=1; after the third tick mag_on=0, done=1 for 3 ticks, then IDLE.
REQ-037 The bench SHALL cover borrow: 1:00 in COOK, one tick -> 0:59; 0:10, one tick -> 0:09.
REQ-038 The bench SHALL cover door open: COOK at 0:45, door_closed=0 coinciding with a tick -> PAUSE, time 0:45, mag_on=0; close and start -> COOK resumes from 0:45.
REQ-039 The bench SHALL cover start blocking and stop priority: start with 0:00 or door open -> stays IDLE; startn and stopn falling together in PAUSE -> IDLE with 0:00.
REQ-040 The bench SHALL cover async reset: clear pulsed mid-cook between clock edges -> mag_on=0 at once, display 0:00, enablen=0.
